stft_window_mult: RTL and testbench
===================================

Name: stft_window_mult

Overview:
- Windowing stage directly upstream of the STFT sample delay buffer.
- Multiplies each incoming time-domain sample by a Hann coefficient indexed by its position in the current frame. Produces rounded, word-sized windowed samples with valid and frame markers.
- Outputs d_out/d_valid connect straight to the buffer's d_in/in_valid.
- Fixed 3-stage pipeline; frame position kept by an internal wrapping counter.

Parameters:
- word_size, 16, sample width; signed two's complement in and out.
- coef_size, 16, coefficient width; unsigned Q0.coef_size (0xFFFF ≈ 0.99998).
- frame_len, 256, samples per frame; power of two, >= 4.
- coef_file, "hann_256.mem", hex file loaded into the coefficient ROM at elaboration; frame_len entries.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  pipeline enable; 0 freezes every register, including the counter.
- in_valid  in  1  d_in holds a sample this cycle.
- d_in  in  word_size  signed input sample.
- restart  in  1  synchronous frame realign; the next accepted sample becomes index 0.
- d_out  out  word_size  signed windowed sample.
- d_valid  out  1  d_out is valid.
- frame_start  out  1  high with d_valid when the output sample had index 0.
- frame_last  out  1  high with d_valid when the output sample had index frame_len-1.

Behaviour:
- Reset (synchronous, active-high; clk and reset are the only clock/reset): d_out=0, d_valid=0, frame_start=0, frame_last=0, idx=0, all pipeline valid bits and data registers 0. Takes priority over en/restart.
- Reset mid-frame: the in-flight pipeline is discarded (no d_valid). The first sample after reset is index 0.
- Accept condition: in_valid & en. idx is $clog2(frame_len) bits.
- On accept: the sample uses the current idx; idx <= idx+1, wrapping frame_len-1 -> 0.
- restart & en:
  - With an accepted sample in the same cycle, that sample is index 0 and idx <= 1.
  - Without one, idx <= 0.
  - restart with en=0 is ignored.
- Pipeline, each stage advancing only when en=1:
  - S1: register sample, valid, and idx flags (is0, islast); ROM read of coef[idx] registered.
  - S2: product = signed sample × signed {1'b0, coef}; width word_size+coef_size+1; registered.
  - S3: d_out = (product + 2^(coef_size-1)) >>> coef_size, arithmetic shift, truncated to word_size. Round half up.
- No overflow is possible because coef < 1.0. The RTL still includes an assertion-style saturation clamp to [-2^(word_size-1), 2^(word_size-1)-1].
- Latency: exactly 3 enabled cycles from accept to d_valid.
- Bubbles propagate as d_valid=0; d_out retains its last value during a bubble.
- frame_start and frame_last are only ever high when d_valid=1. Both are high together only if frame_len=1, which is disallowed.
- en=0: all outputs hold their previous values (a held d_valid=1 is not a new sample; the downstream buffer is run on the same en).
- ROM contents: coef[n] = round(65535·0.5·(1−cos(2πn/frame_len))), giving coef[0]=0, coef[frame_len/4]=32768, coef[frame_len/2]=65535.

Optional Feature:
- Macro STFT_WINDOW_BYPASS_EN.
- Defined: adds input port bypass (1 bit).
  - When bypass=1 at S1 capture, that sample passes unscaled: d_out = sample, with the same 3-cycle latency.
  - idx, frame_start and frame_last behave identically.
  - bypass may change per sample with no bubbles.
- Undefined: no bypass port; every sample is windowed.

Test Plan:
- Reset, then 256 consecutive valid samples of 0x4000, en=1 -> first d_valid exactly 3 cycles after the first accept. Outputs at idx 0/64/128 = 0x0000/0x2000/0x4000. frame_start on output 0, frame_last on output 255.
- Sample 0x8000 (−32768) at idx 128 -> d_out=0x8001 (−32767). Sample 0x7FFF at idx 128 -> 0x7FFF.
- in_valid toggled 1,0,1,0 with en=1 -> d_valid mirrors the pattern 3 cycles later; idx advances only on valid samples.
- en=0 for 5 cycles mid-stream -> outputs and idx frozen. Resumes with no lost or duplicated sample; total latency is 3 enabled cycles.
- restart asserted with the accepted sample at idx 100 -> that output has frame_start=1 and window 0 (d_out=0). The next sample is treated as idx 1.
- reset pulsed while 3 samples are in flight -> none emerge (d_valid stays 0). The next sample's output has frame_start=1. With STFT_WINDOW_BYPASS_EN and bypass=1, input 0x1234 gives d_out=0x1234.

Source files
------------

// File: rtl/stft_window_mult.sv
// stft_window_mult: Hann windowing stage that feeds the STFT sample delay buffer.
// Each accepted sample is multiplied by coef[idx], where idx is the sample's
// position in the current frame. The result is rounded half-up and clamped.
// The pipeline has three stages: coefficient lookup, multiply, and round/clamp.
// Every register in the pipeline is gated by en.
//
// The coefficient table is built at elaboration from the Hann formula
// round((2^coef_size-1) * 0.5 * (1 - cos(2*pi*n/frame_len))).
// Building it in the RTL means the ROM and the window formula cannot drift
// apart. coef_file is kept only so the parameter interface stays intact.
//
// Optional macro STFT_WINDOW_BYPASS_EN adds a per-sample 'bypass' input.
// A bypassed sample reaches d_out unscaled, with the same latency and frame
// markers as a windowed sample.
module stft_window_mult #(
  parameter int    word_size = 16,
  parameter int    coef_size = 16,
  parameter int    frame_len = 256,
  parameter string coef_file = "hann_256.mem"
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [word_size-1:0] d_in,
  input  logic                 restart,
  output logic [word_size-1:0] d_out,
  output logic                 d_valid,
  output logic                 frame_start,
  output logic                 frame_last
`ifdef STFT_WINDOW_BYPASS_EN
  ,
  input  logic                 bypass
`endif
);

  localparam int IDX_W  = $clog2(frame_len);
  localparam int PROD_W = word_size + coef_size + 1;
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(frame_len - 1);
  localparam logic signed [PROD_W-1:0] RND     = PROD_W'(1) <<< (coef_size - 1);
  localparam logic signed [word_size:0] SAT_MAX = (word_size + 1)'((2 ** (word_size - 1)) - 1);
  localparam logic signed [word_size:0] SAT_MIN = -((word_size + 1)'(2 ** (word_size - 1)));

  // The file name is never opened; the table always comes from the formula below.
  if (coef_file == "") begin : g_coef_unnamed
  end

  // Hann coefficient computed with a Taylor series for cos.
  // The angle is first reduced to [-pi, pi] so that the series converges quickly.
  // The small bias added before truncation makes the exact x.5 points
  // (n = frame_len/4 and 3*frame_len/4) round up to 2^(coef_size-1).
  function automatic logic [coef_size-1:0] hann_coef(input int n);
    real pi_v;
    real x;
    real term;
    real c;
    real v;
    pi_v = 3.14159265358979323846;
    x    = 2.0 * pi_v * real'(n) / real'(frame_len);
    if (x > pi_v) x = x - 2.0 * pi_v;
    c    = 1.0;
    term = 1.0;
    for (int k = 1; k <= 24; k++) begin
      term = -term * x * x / real'((2 * k - 1) * (2 * k));
      c    = c + term;
    end
    v = ((2.0 ** coef_size) - 1.0) * 0.5 * (1.0 - c) + 0.5 + 1.0e-6;
    return coef_size'($rtoi(v));
  endfunction

  logic [coef_size-1:0] coef_rom [frame_len];

  for (genvar g = 0; g < frame_len; g++) begin : g_rom
    assign coef_rom[g] = hann_coef(g);
  end

  logic byp_in;
`ifdef STFT_WINDOW_BYPASS_EN
  assign byp_in = bypass;
`else
  assign byp_in = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Frame index counter
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic [IDX_W-1:0] idx_cur;
  logic             accept;

  // Select the index for this cycle's sample (restart forces 0), then compute the next index.
  always_comb begin
    accept  = in_valid & en;
    idx_cur = restart ? '0 : idx_q;
    idx_d   = idx_q;
    if (en) begin
      if (accept) begin
        idx_d = idx_cur + IDX_W'(1);
      end else if (restart) begin
        idx_d = '0;
      end
    end
  end

  // Index register; the counter wraps naturally because frame_len is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // S1: capture sample, frame flags and coefficient
  // ---------------------------------------------------------------------------
  logic                 s1_valid_q;
  logic                 s1_is0_q;
  logic                 s1_islast_q;
  logic                 s1_byp_q;
  logic [word_size-1:0] s1_data_q;
  logic [coef_size-1:0] s1_coef_q;

  // Stage 1 register: register the sample and its frame flags, and read the ROM at idx_cur.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_is0_q    <= 1'b0;
      s1_islast_q <= 1'b0;
      s1_byp_q    <= 1'b0;
      s1_data_q   <= '0;
      s1_coef_q   <= '0;
    end else if (en) begin
      s1_valid_q  <= in_valid;
      s1_is0_q    <= in_valid & (idx_cur == '0);
      s1_islast_q <= in_valid & (idx_cur == LAST_IDX);
      if (in_valid) begin
        s1_data_q <= d_in;
        s1_coef_q <= coef_rom[idx_cur];
        s1_byp_q  <= byp_in;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: multiply
  // ---------------------------------------------------------------------------
  logic signed [PROD_W-1:0] prod_d;
  logic signed [PROD_W-1:0] s2_prod_q;
  logic                     s2_valid_q;
  logic                     s2_is0_q;
  logic                     s2_islast_q;

  // Compute the product. A bypassed sample is scaled by 2^coef_size, so the round/shift in S3 returns it unchanged.
  always_comb begin
    if (s1_byp_q) begin
      prod_d = PROD_W'($signed(s1_data_q)) <<< coef_size;
    end else begin
      prod_d = PROD_W'($signed(s1_data_q)) * PROD_W'($signed({1'b0, s1_coef_q}));
    end
  end

  // Stage 2 register: hold the product and pass the flags along.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_prod_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_is0_q    <= 1'b0;
      s2_islast_q <= 1'b0;
    end else if (en) begin
      s2_valid_q  <= s1_valid_q;
      s2_is0_q    <= s1_is0_q;
      s2_islast_q <= s1_islast_q;
      if (s1_valid_q) begin
        s2_prod_q <= prod_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S3: round half up, arithmetic shift, clamp
  // ---------------------------------------------------------------------------
  logic signed [PROD_W-1:0]  rnd_sum;
  logic signed [word_size:0] shifted;
  logic [word_size-1:0]      out_d;

  // Round half up, shift right, then clamp. A window below 1.0 never trips the clamp; it guards against a corrupted coefficient.
  always_comb begin
    rnd_sum = s2_prod_q + RND;
    shifted = (word_size + 1)'(rnd_sum >>> coef_size);
    out_d   = shifted[word_size-1:0];
    if (shifted > SAT_MAX) begin
      out_d = SAT_MAX[word_size-1:0];
    end else if (shifted < SAT_MIN) begin
      out_d = SAT_MIN[word_size-1:0];
    end
  end

  logic [word_size-1:0] d_out_q;
  logic                 d_valid_q;
  logic                 frame_start_q;
  logic                 frame_last_q;

  // Output register: d_out keeps its last value through bubbles, and the markers are qualified by valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_out_q       <= '0;
      d_valid_q     <= 1'b0;
      frame_start_q <= 1'b0;
      frame_last_q  <= 1'b0;
    end else if (en) begin
      d_valid_q     <= s2_valid_q;
      frame_start_q <= s2_valid_q & s2_is0_q;
      frame_last_q  <= s2_valid_q & s2_islast_q;
      if (s2_valid_q) begin
        d_out_q <= out_d;
      end
    end
  end

  assign d_out       = d_out_q;
  assign d_valid     = d_valid_q;
  assign frame_start = frame_start_q;
  assign frame_last  = frame_last_q;

endmodule

// File: tb/tb_stft_window_mult.sv
// Bench for stft_window_mult: a table of single-sample vectors, hand-written
// multi-cycle sequences, and a long random run. Every cycle is compared
// against a queue-based reference model.
module tb_stft_window_mult;

  localparam int W = 16;
  localparam int C = 16;
  localparam int N = 256;
`ifdef STFT_WINDOW_BYPASS_EN
  localparam bit BYP_EN = 1'b1;
`else
  localparam bit BYP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         in_valid;
  logic [W-1:0] d_in;
  logic         restart;
  logic         bypass;
  logic [W-1:0] d_out;
  logic         d_valid;
  logic         frame_start;
  logic         frame_last;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stft_window_mult #(
    .word_size(W),
    .coef_size(C),
    .frame_len(N)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .in_valid   (in_valid),
    .d_in       (d_in),
    .restart    (restart),
    .d_out      (d_out),
    .d_valid    (d_valid),
    .frame_start(frame_start),
    .frame_last (frame_last)
`ifdef STFT_WINDOW_BYPASS_EN
    ,
    .bypass     (bypass)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit          v;
    logic [15:0] d;
    bit          fs;
    bit          fl;
  } ent_t;

  ent_t        pipe_q[$];
  int          m_idx;
  bit          e_valid;
  bit          e_fs;
  bit          e_fl;
  logic [15:0] e_out;

  function automatic int coef_of(int n);
    real v;
    v = 65535.0 * 0.5 * (1.0 - $cos(2.0 * 3.14159265358979323846 * real'(n) / real'(N))) + 0.5 + 1.0e-6;
    return int'($floor(v));
  endfunction

  function automatic logic [15:0] window(int s, int n, bit byp);
    longint p;
    longint r;
    if (byp) return 16'(s);
    p = longint'(s) * longint'(coef_of(n)) + 64'sd32768;
    if (p >= 0) r = p / 65536;
    else        r = -((-p + 65535) / 65536);
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  function automatic void model_reset();
    ent_t b;
    b.v = 1'b0; b.d = '0; b.fs = 1'b0; b.fl = 1'b0;
    pipe_q.delete();
    pipe_q.push_back(b);
    pipe_q.push_back(b);
    m_idx   = 0;
    e_valid = 1'b0;
    e_fs    = 1'b0;
    e_fl    = 1'b0;
    e_out   = '0;
  endfunction

  function automatic void model_update();
    ent_t e;
    ent_t o;
    int   cur;
    if (reset) begin
      model_reset();
    end else if (en) begin
      e.v = in_valid; e.d = '0; e.fs = 1'b0; e.fl = 1'b0;
      cur = restart ? 0 : m_idx;
      if (in_valid) begin
        e.d   = window(int'($signed(d_in)), cur, BYP_EN && bypass);
        e.fs  = (cur == 0);
        e.fl  = (cur == N - 1);
        m_idx = (cur + 1) % N;
      end else if (restart) begin
        m_idx = 0;
      end
      pipe_q.push_back(e);
      o       = pipe_q.pop_front();
      e_valid = o.v;
      e_fs    = o.v && o.fs;
      e_fl    = o.v && o.fl;
      if (o.v) e_out = o.d;
    end
  endfunction

  // ---------------- drive / compare ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit v, input logic [15:0] d,
                      input bit rs, input bit b);
    reset = r; en = e; in_valid = v; d_in = d; restart = rs; bypass = b;
    @(posedge clk);
    model_update();
    @(negedge clk);
    checks++;
    if (d_valid !== e_valid || frame_start !== e_fs || frame_last !== e_fl || d_out !== e_out) begin
      errors++;
      $display("FAIL model t=%0t: got v=%0b fs=%0b fl=%0b out=%h expected v=%0b fs=%0b fl=%0b out=%h",
               $time, d_valid, frame_start, frame_last, d_out, e_valid, e_fs, e_fl, e_out);
    end
  endtask

  typedef struct {
    int          idx;
    logic [15:0] din;
    logic [15:0] dout;
    bit          fs;
    bit          fl;
  } vec_t;

  vec_t vt[12];

  initial begin
    int   lat;
    int   cnt;
    bit   dv[8];
    logic [15:0] held_out;
    bit          held_v;

    vt[0]  = '{0,   16'h4000, 16'h0000, 1'b1, 1'b0};
    vt[1]  = '{64,  16'h4000, 16'h2000, 1'b0, 1'b0};
    vt[2]  = '{128, 16'h4000, 16'h4000, 1'b0, 1'b0};
    vt[3]  = '{192, 16'h4000, 16'h2000, 1'b0, 1'b0};
    vt[4]  = '{255, 16'h4000, 16'h0003, 1'b0, 1'b1};
    vt[5]  = '{128, 16'h8000, 16'h8001, 1'b0, 1'b0};
    vt[6]  = '{128, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0};
    vt[7]  = '{128, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
    vt[8]  = '{64,  16'hFFFF, 16'h0000, 1'b0, 1'b0};
    vt[9]  = '{64,  16'h0001, 16'h0001, 1'b0, 1'b0};
    vt[10] = '{0,   16'h7FFF, 16'h0000, 1'b1, 1'b0};
    vt[11] = '{64,  16'h8000, 16'hC000, 1'b0, 1'b0};

    reset = 1'b1; en = 1'b0; in_valid = 1'b0; d_in = '0; restart = 1'b0; bypass = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset state.
    step(1, 0, 0, 16'h0, 0, 0);
    chk("reset_dvalid", int'(d_valid), 0);
    chk("reset_dout", int'(d_out), 0);
    chk("reset_markers", int'({frame_start, frame_last}), 0);

    // Table of single samples placed at a given frame index.
    foreach (vt[i]) begin
      step(1, 1, 0, 16'h0, 0, 0);
      for (int k = 0; k < vt[i].idx; k++) step(0, 1, 1, 16'h0100, 0, 0);
      step(0, 1, 1, vt[i].din, 0, 0);
      step(0, 1, 0, 16'h0, 0, 0);
      step(0, 1, 0, 16'h0, 0, 0);
      chk($sformatf("vec%0d_valid", i), int'(d_valid), 1);
      chk($sformatf("vec%0d_dout", i), int'(d_out), int'(vt[i].dout));
      chk($sformatf("vec%0d_fs", i), int'(frame_start), int'(vt[i].fs));
      chk($sformatf("vec%0d_fl", i), int'(frame_last), int'(vt[i].fl));
    end

    // Full frame of 0x4000: check latency, window points and frame markers.
    step(1, 1, 0, 16'h0, 0, 0);
    lat = -1; cnt = 0;
    for (int i = 0; i < 260; i++) begin
      step(0, 1, (i < 256), 16'h4000, 0, 0);
      if (d_valid) begin
        if (lat < 0) begin
          lat = i + 1;
          chk("latency", lat, 3);
        end
        if (cnt == 0)   chk("frame_out0", int'({frame_start, d_out}), int'({1'b1, 16'h0000}));
        if (cnt == 64)  chk("frame_out64", int'(d_out), 16'h2000);
        if (cnt == 128) chk("frame_out128", int'(d_out), 16'h4000);
        if (cnt == 255) chk("frame_last255", int'(frame_last), 1);
        cnt++;
      end
    end
    chk("frame_count", cnt, 256);

    // in_valid 1,0,1,0: d_valid follows the same pattern 3 cycles later.
    step(1, 1, 0, 16'h0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, (i < 4) && (i % 2 == 0), 16'h4000, 0, 0);
      dv[i] = d_valid;
      if (i == 4) chk("toggle_idx1_out", int'(d_out), 16'h0003);
    end
    chk("toggle_pattern", int'({dv[2], dv[3], dv[4], dv[5]}), 4'b1010);

    // en=0 for 5 cycles with samples in flight: outputs hold, nothing lost.
    step(1, 1, 0, 16'h0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 1, 16'(16'h1000 + i * 16'h0321), 0, 0);
    held_out = d_out; held_v = d_valid;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 16'h7777, 1, 0);
      chk("freeze_hold", int'({d_valid, d_out}), int'({held_v, held_out}));
    end
    for (int i = 0; i < 4; i++) step(0, 1, 0, 16'h0, 0, 0);

    // restart on the sample at idx 100: that sample becomes index 0, and the next is index 1.
    step(1, 1, 0, 16'h0, 0, 0);
    for (int i = 0; i < 100; i++) step(0, 1, 1, 16'h4000, 0, 0);
    step(0, 1, 1, 16'h4000, 1, 0);
    step(0, 1, 1, 16'h4000, 0, 0);
    step(0, 1, 0, 16'h0, 0, 0);
    chk("restart_fs", int'(frame_start), 1);
    chk("restart_dout", int'(d_out), 0);
    step(0, 1, 0, 16'h0, 0, 0);
    chk("restart_next_dout", int'({frame_start, d_out}), int'({1'b0, 16'h0003}));

    // Reset with 3 samples in flight: none emerge, and the next sample is index 0.
    for (int i = 0; i < 3; i++) step(0, 1, 1, 16'h4000, 0, 0);
    step(1, 1, 1, 16'h4000, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 16'h0, 0, 0);
      chk("flush_no_valid", int'(d_valid), 0);
    end
    step(0, 1, 1, 16'h4000, 0, 0);
    step(0, 1, 0, 16'h0, 0, 0);
    step(0, 1, 0, 16'h0, 0, 0);
    chk("post_reset_fs", int'({d_valid, frame_start}), 2'b11);
`ifdef STFT_WINDOW_BYPASS_EN
    step(0, 1, 1, 16'h1234, 0, 1);
    step(0, 1, 0, 16'h0, 0, 0);
    step(0, 1, 0, 16'h0, 0, 0);
    chk("bypass_dout", int'(d_out), 16'h1234);
`endif

    // Randomized traffic checked against the model on every cycle.
    step(1, 1, 0, 16'h0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 9) < 7),
           16'($urandom),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
